sync_fifo: RTL
==============

// Module: sync_fifo
// PURPOSE
//  Single-clock parametrised FIFO: the synchronous successor to the dual-clock FIFO, for buffering within one domain.
//  Adds configurable width/depth, occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow
//  flags, a synchronous flush and a selectable read mode (registered or first-word-fall-through).
// PARAMETERS
//  DATA_W     8   data width in bits
//  DEPTH      16  number of entries; power of 2, >= 2
//  AF_THRESH  12  almost_full asserts when count >= AF_THRESH; range 1..DEPTH
//  AE_THRESH  2   almost_empty asserts when count <= AE_THRESH; range 0..DEPTH-1
//  FWFT       0   0 = registered read (rdata 1 cycle after accepted r_en); 1 = first-word-fall-through
// PORTS
//  clk           in   1                  clock; all logic on rising edge
//  rst           in   1                  asynchronous reset, active-high
//  clr           in   1                  synchronous flush, priority over w_en/r_en
//  w_en          in   1                  write request
//  wdata         in   DATA_W             write data
//  w_full        out  1                  FIFO full; writes rejected
//  r_en          in   1                  read request (FWFT: pop)
//  r_empty       out  1                  FIFO empty (FWFT: no valid rdata)
//  rdata         out  DATA_W             read data
//  count         out  $clog2(DEPTH)+1    entries held, 0..DEPTH
//  almost_full   out  1                  count >= AF_THRESH
//  almost_empty  out  1                  count <= AE_THRESH
//  overflow      out  1                  sticky: write attempted while full
//  underflow     out  1                  sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (async, rst=1): pointers=0, count=0, w_full=0, r_empty=1, almost_full=0, almost_empty=1,
//    overflow=0, underflow=0, rdata=0. Storage array not reset.
//  - Pointers $clog2(DEPTH)+1 bits incl. wrap bit; natural wrap at DEPTH. Full: MSBs differ, rest equal.
//  - All status outputs registered; values reflect state after last rising edge.
//  - Write accepted iff w_en && !w_full; stored at wr_ptr, wr_ptr++ at that edge.
//  - Read accepted iff r_en && !r_empty; rd_ptr++ at that edge.
//  - Full + w_en + r_en same cycle: read accepted, write rejected, overflow set.
//  - Empty + w_en + r_en same cycle: write accepted, read rejected, underflow set.
//  - Both accepted: count unchanged, flags unchanged.
//  - count: +1 write-only, -1 read-only; almost_full/almost_empty/w_full/r_empty updated same edge as count.
//  - Write into empty FIFO: r_empty low the cycle after the write edge (1-cycle latency, both modes).
//  - FWFT=0: rdata loaded from head at accepted-read edge, valid next cycle; holds value otherwise.
//  - FWFT=1: rdata = head entry whenever r_empty=0 (combinational from storage); r_en pops; rdata when empty is don't-care.
//  - overflow/underflow set on the edge after the offending request; cleared only by rst or clr.
//  - clr=1: pointers=0, count=0, flags and sticky errors return to reset values at that edge; w_en/r_en that
//    cycle ignored (no write, no error flagged); rdata holds (FWFT=0).
//  - rst mid-operation: all state cleared immediately; contents lost.
//  - Illegal parameters (DEPTH not power of 2 or < 2, thresholds out of range): $fatal at elaboration.
// TESTING  (DATA_W=8, DEPTH=16, AF_THRESH=12, AE_THRESH=2)
//  1. Write 0x00..0x0F, no reads -> count 16, w_full=1, almost_full from count 12; read all, FWFT=0 -> 0x00..0x0F in order, rdata 1 cycle after r_en, r_empty=1 after 16th read.
//  2. Full FIFO, w_en=1 wdata=0xAA one cycle -> write dropped, count stays 16, overflow=1 and remains until clr.
//  3. Empty FIFO, r_en=1 -> underflow=1, count 0, rdata unchanged; same cycle w_en=1 wdata=0x55 -> count 1, r_empty=0 next cycle.
//  4. Full FIFO, w_en=r_en=1 -> read returns oldest word, write rejected, count 15, overflow=1; half-full w_en=r_en=1 for 40 cycles -> count constant, pointers wrap, data order preserved.
//  5. FWFT=1: write 0x3C to empty -> next cycle r_empty=0, rdata=0x3C with no r_en; r_en=1 -> r_empty=1.
//  6. 10 entries + overflow set, clr=1 with w_en=1 -> count 0, r_empty=1, overflow=0, no write; rst pulse mid-burst -> all outputs at reset values immediately.

Source files
------------

// File: rtl/sync_fifo_if.sv
// Handshake and status bundle for the single-clock FIFO.
// master: the user side, which drives requests and observes status.
// slave:  the FIFO side.
interface sync_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              clr;
  logic              w_en;
  logic [DATA_W-1:0] wdata;
  logic              w_full;
  logic              r_en;
  logic              r_empty;
  logic [DATA_W-1:0] rdata;
  logic [CW-1:0]     count;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output clr, w_en, wdata, r_en,
    input  w_full, r_empty, rdata, count,
    input  almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  clr, w_en, wdata, r_en,
    output w_full, r_empty, rdata, count,
    output almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO with occupancy count, almost-full and
// almost-empty thresholds, sticky overflow/underflow flags, a synchronous
// flush and a choice of registered or first-word-fall-through read data.
// Pointers carry one extra wrap bit, so full and empty are distinguishable
// and the occupancy is simply the pointer difference.
module sync_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic      clk,
  input  logic      rst,
  sync_fifo_if.slave fif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_LVL  = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LVL  = PW'(AE_THRESH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "sync_fifo: DEPTH must be a power of 2 and at least 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $fatal(1, "sync_fifo: AF_THRESH must lie in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "sync_fifo: AE_THRESH must lie in 0..DEPTH-1");
  end
  if (DATA_W < 1 || (FWFT != 0 && FWFT != 1)) begin : g_bad_misc
    $fatal(1, "sync_fifo: DATA_W must be >= 1 and FWFT must be 0 or 1");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     count_q, count_d;
  logic              w_full_q, w_full_d;
  logic              r_empty_q, r_empty_d;
  logic              af_q, af_d;
  logic              ae_q, ae_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_acc;
  logic              rd_acc;

  // Next-state: accept decisions, pointer moves, error capture, flush, status
  always_comb begin
    wr_acc   = fif.w_en && !w_full_q  && !fif.clr;
    rd_acc   = fif.r_en && !r_empty_q && !fif.clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    rdata_d  = rdata_q;

    if (fif.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (FWFT == 0) begin
          rdata_d = mem_q[rd_ptr_q[AW-1:0]];
        end
      end
      if (fif.w_en && w_full_q) begin
        ovf_d = 1'b1;
      end
      if (fif.r_en && r_empty_q) begin
        udf_d = 1'b1;
      end
    end

    count_d   = wr_ptr_d - rd_ptr_d;
    w_full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    r_empty_d = (wr_ptr_d == rd_ptr_d);
    af_d      = (count_d >= AF_LVL);
    ae_d      = (count_d <= AE_LVL);
  end

  // Control and status registers; async reset returns the FIFO to empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      w_full_q  <= 1'b0;
      r_empty_q <= 1'b1;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      w_full_q  <= w_full_d;
      r_empty_q <= r_empty_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      rdata_q   <= rdata_d;
    end
  end

  // Storage write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= fif.wdata;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign fif.rdata = mem_q[rd_ptr_q[AW-1:0]];
  end else begin : g_reg
    assign fif.rdata = rdata_q;
  end

  assign fif.w_full       = w_full_q;
  assign fif.r_empty      = r_empty_q;
  assign fif.count        = count_q;
  assign fif.almost_full  = af_q;
  assign fif.almost_empty = ae_q;
  assign fif.overflow     = ovf_q;
  assign fif.underflow    = udf_q;
endmodule
